tmr_fault_monitor: RTL

- Sits directly downstream of the TMR word voter and consumes its per-cycle `error` / `error_cba` outcome.
- Keeps a leaky, saturating mismatch counter per replica.
- When one replica's counter reaches a threshold, requests a resynchronisation of that replica over a req/ack handshake.
- Latches a sticky fatal flag on any uncorrectable (triple-disagree) vote.

---
 rtl/tmr_fault_monitor_pkg.sv | 14 +
 rtl/tmr_fault_counter.sv | 26 ++
 rtl/tmr_fault_monitor.sv | 104 ++++++++++
 3 files changed

// File: rtl/tmr_fault_monitor_pkg.sv
// tmr_fault_monitor_pkg: shared types and constants for the TMR fault monitor
package tmr_fault_monitor_pkg;

    localparam int NumReplicas = 3;

    typedef logic [1:0] replica_id_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FATAL
    } state_e;

endpackage

// File: rtl/tmr_fault_counter.sv
// tmr_fault_counter: saturating up/down counter, priority clear > increment > decrement
module tmr_fault_counter
    import tmr_fault_monitor_pkg::*;
#(
    parameter int CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o
);

    logic [CntWidth-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_cnt <= '0;
        else if (clr_i) r_cnt <= '0;
        else if (inc_i) r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        else if (dec_i && |r_cnt) r_cnt <= r_cnt - 1'b1;
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/tmr_fault_monitor.sv
// tmr_fault_monitor: per-replica leaky mismatch counters, resync req/ack FSM and sticky fatal flag
module tmr_fault_monitor
    import tmr_fault_monitor_pkg::*;
#(
    parameter int CntWidth    = 8,
    parameter int Threshold   = 4,
    parameter int DecayPeriod = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            valid_i,
    input  logic                            error_i,
    input  logic [2:0]                      error_cba_i,
    input  logic                            clear_i,
    output logic                            resync_req_o,
    output logic [1:0]                      resync_id_o,
    input  logic                            resync_ack_i,
    output logic [NumReplicas*CntWidth-1:0] fault_cnt_o,
    output logic                            fatal_o
);

    localparam int TimerWidth = $clog2(DecayPeriod);

    state_e                  r_state;
    logic                    r_req;
    replica_id_t             r_id;
    logic                    r_fatal;
    logic [TimerWidth-1:0]   r_timer;
    logic [CntWidth-1:0]     w_cnt [NumReplicas];
    logic [NumReplicas-1:0]  w_hit;
    logic [NumReplicas-1:0]  w_ack_clr;
    logic                    w_vote_ok;
    logic                    w_clean;
    logic                    w_decay;
    logic                    w_ack;

    assign w_vote_ok = valid_i && !error_i;
    assign w_clean   = w_vote_ok && error_cba_i == '0;
    assign w_decay   = w_clean && r_timer == TimerWidth'(DecayPeriod - 1);
    assign w_ack     = r_state == REQ && resync_ack_i;

    for (genvar g = 0; g < NumReplicas; g++) begin : g_rep
        assign w_hit[g]     = w_cnt[g] >= CntWidth'(Threshold);
        assign w_ack_clr[g] = w_ack && r_id == replica_id_t'(g);
        tmr_fault_counter #(.CntWidth(CntWidth)) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clear_i || w_ack_clr[g]),
            .inc_i  (w_vote_ok && error_cba_i[g]),
            .dec_i  (w_decay),
            .cnt_o  (w_cnt[g])
        );
        assign fault_cnt_o[g*CntWidth +: CntWidth] = w_cnt[g];
    end

    // Any valid vote that is not clean restarts the quiet-period measurement.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_timer <= '0;
        else if (clear_i) r_timer <= '0;
        else if (valid_i) r_timer <= (w_clean && !w_decay) ? r_timer + 1'b1 : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_fatal <= 1'b0;
        else if (clear_i) r_fatal <= 1'b0;
        else if (valid_i && error_i) r_fatal <= 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_id    <= '0;
        end else if (clear_i) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_fatal) begin
                        r_state <= FATAL;
                    end else if (|w_hit) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_id    <= w_hit[0] ? 2'd0 : w_hit[1] ? 2'd1 : 2'd2;
                    end
                end
                REQ: begin
                    if (resync_ack_i) begin
                        r_req   <= 1'b0;
                        r_state <= (r_fatal || (valid_i && error_i)) ? FATAL : IDLE;
                    end
                end
                FATAL: r_state <= FATAL;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign resync_req_o = r_req;
    assign resync_id_o  = r_id;
    assign fatal_o      = r_fatal;

endmodule
